i2s_adc_rx: RTL

- Receive-side counterpart of the audio playback path: deserialises the codec ADC stream (I2S, BCLK/LRCLK supplied by the codec) into parallel 24-bit left/right samples in the clk100 domain.
- Emits a one-cycle sample_valid strobe per completed stereo frame.
- Sits beside audio_top; its outputs feed loopback, level metering and the game's pitch-detect logic.

---
 rtl/i2s_adc_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: deserialises the codec I2S ADC stream into 24-bit L/R samples in the clk100 domain
module i2s_adc_rx #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              enable,
  input  logic              ac_bclk,
  input  logic              ac_lrclk,
  input  logic              ac_sdata,
  output logic [DATA_W-1:0] audio_l_out,
  output logic [DATA_W-1:0] audio_r_out,
  output logic              sample_valid,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d, lr_sync_q, lr_sync_d, sd_sync_q, sd_sync_d;
  logic                   bclk_prev_q, bclk_prev_d, lr_prev_q, lr_prev_d, chan_q, chan_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [DATA_W-2:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      l_hold_q, l_hold_d, audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic                   bclk_s, lr_s, sd_s, rise, lr_chg, last;
  logic [DATA_W-1:0]      word;
  assign audio_l_out  = audio_l_q;
  assign audio_r_out  = audio_r_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], ac_bclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], ac_lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], ac_sdata};
    bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    lr_s        = lr_sync_q[SYNC_STAGES-1];
    sd_s        = sd_sync_q[SYNC_STAGES-1];
    rise        = bclk_s & ~bclk_prev_q;
    lr_chg      = rise & (lr_s != lr_prev_q);
    word        = {shreg_q, sd_s};
    last        = bitcnt_q == CW'(DATA_W - 1);
    bclk_prev_d = bclk_s;
    lr_prev_d   = rise ? lr_s : lr_prev_q;
    state_d     = state_q;
    chan_d      = chan_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    l_hold_d    = l_hold_q;
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    if (!enable) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (lr_chg && !lr_s) begin
          state_d = SKIP;
          chan_d  = 1'b0;
        end
        // The lr-change rise itself carried the delay bit; the next rise is the MSB.
        SKIP: begin
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
        SHIFT: if (rise) begin
          if (last) begin
            state_d  = lr_chg ? SKIP : WAIT;
            chan_d   = lr_chg ? lr_s : chan_q;
            l_hold_d = chan_q ? l_hold_q : word;
            if (chan_q) begin
              audio_l_d = l_hold_q;
              audio_r_d = word;
              valid_d   = 1'b1;
            end
          end else if (lr_chg) begin
            err_d   = 1'b1;
            state_d = lr_s ? IDLE : SKIP;
            chan_d  = 1'b0;
          end else begin
            shreg_d  = word[DATA_W-2:0];
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
        WAIT: if (lr_chg) begin
          state_d = SKIP;
          chan_d  = lr_s;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      chan_q      <= 1'b0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      l_hold_q    <= '0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lr_prev_q   <= lr_prev_d;
      chan_q      <= chan_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      l_hold_q    <= l_hold_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end
endmodule
